matrix_add_sequencer: RTL and testbench



---
 rtl/matrix_add_sequencer.sv | 113 +++++++++++
 tb/tb_matrix_add_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_sequencer.sv
// Element-wise N x N matrix adder time-multiplexed onto one shared W-bit adder.
// Optional SAT_ADD_EN: saturate each element sum at 2^W-1 instead of wrapping.
module matrix_add_sequencer #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_in,
  input  logic [N*N*W-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] c_out,
  output logic             carry,
  output logic             busy
);

  localparam int unsigned NN = N * N;
  localparam int unsigned KW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NN*W-1:0]     a_q, a_d;
  logic [NN*W-1:0]     b_q, b_d;
  logic [NN*W-1:0]     c_q, c_d;
  logic                carry_q, carry_d;
  logic [KW-1:0]       k_q, k_d;

  logic [W-1:0]        a_sel, b_sel, res;
  logic [W:0]          sum;

  // Element k sits at bits [(NN-1-k)*W +: W]; the loop builds a constant-select mux.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      if (k_q == KW'(i)) begin
        a_sel = a_q[(NN-1-i)*W +: W];
        b_sel = b_q[(NN-1-i)*W +: W];
      end
    end
    sum = {1'b0, a_sel} + {1'b0, b_sel};
`ifdef SAT_ADD_EN
    res = sum[W] ? '1 : sum[W-1:0];
`else
    res = sum[W-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    carry_d = carry_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = 1'b0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NN; i++) begin
          if (k_q == KW'(i)) c_d[(NN-1-i)*W +: W] = res;
        end
        carry_d = carry_q | sum[W];
        if (k_q == KW'(NN - 1)) state_d = DONE;
        else                    k_d = k_q + 1'b1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign c_out     = c_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_matrix_add_sequencer.sv
// Directed self-checking bench for matrix_add_sequencer (N=2 and N=1 instances).
module tb_matrix_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, carry, busy;
  logic [31:0] a_in, b_in, c_out;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, carry1, busy1;
  logic [7:0]  a1, b1, c1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_add_sequencer #(.N(2), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .c_out(c_out), .carry(carry), .busy(busy)
  );

  matrix_add_sequencer #(.N(1), .W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a_in(a1), .b_in(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .c_out(c1), .carry(carry1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input string tag, input int budget);
    int c;
    c = 0;
    while (out_valid !== 1'b1 && c < budget) begin
      step();
      c++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
    step();
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    rst = 1'b0;

    // Basic: {1,2,3,4} + {10,20,30,40}, latency 4 cycles
    run_op(32'h01020304, 32'h0A141E28);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_in_ready_run", 64'(in_ready), 64'd0);
    step(); step(); step();
    chk("basic_not_yet_valid", 64'(out_valid), 64'd0);
    step();
    chk("basic_valid_at_T4", 64'(out_valid), 64'd1);
    chk("basic_c_out", 64'(c_out), 64'h0B16212C);
    chk("basic_carry", 64'(carry), 64'd0);

    // Backpressure: result held for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_c_out", 64'(c_out), 64'h0B16212C);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    consume();
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_hold_c_out", 64'(c_out), 64'h0B16212C);

    // Overflow, with in_valid pulsed mid-RUN carrying different data
    run_op(32'hC8000000, 32'h64000000);
    a_in = 32'hFFFFFFFF; b_in = 32'hFFFFFFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out("ovf_timeout", 10);
`ifdef SAT_ADD_EN
    chk("ovf_c_out", 64'(c_out), 64'hFF000000);
`else
    chk("ovf_c_out", 64'(c_out), 64'h2C000000);
`endif
    chk("ovf_carry", 64'(carry), 64'd1);
    a_in = '0; b_in = '0;
    consume();

    // Next op must start with carry cleared
    run_op(32'h01020304, 32'h05050505);
    wait_out("b2b_timeout", 10);
    chk("b2b_c_out", 64'(c_out), 64'h06070809);
    chk("b2b_carry", 64'(carry), 64'd0);
    consume();

    // Reset in the 2nd RUN cycle
    run_op(32'h10101010, 32'h01010101);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_carry", 64'(carry), 64'd0);
    chk("mrst_c_out", 64'(c_out), 64'd0);

    run_op(32'hFF010203, 32'h01010101);
    wait_out("post_rst_timeout", 10);
`ifdef SAT_ADD_EN
    chk("post_rst_c_out", 64'(c_out), 64'hFF020304);
`else
    chk("post_rst_c_out", 64'(c_out), 64'h00020304);
`endif
    chk("post_rst_carry", 64'(carry), 64'd1);
    consume();

    // N=1 corner
    a1 = 8'd7; b1 = 8'd9; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0; a1 = '0; b1 = '0;
    chk("n1_busy", 64'(busy1), 64'd1);
    chk("n1_not_valid", 64'(out_valid1), 64'd0);
    step();
    chk("n1_valid", 64'(out_valid1), 64'd1);
    chk("n1_c_out", 64'(c1), 64'd16);
    chk("n1_carry", 64'(carry1), 64'd0);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("n1_in_ready", 64'(in_ready1), 64'd1);

    a1 = 8'd200; b1 = 8'd100; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    step();
`ifdef SAT_ADD_EN
    chk("n1_ovf_c_out", 64'(c1), 64'd255);
`else
    chk("n1_ovf_c_out", 64'(c1), 64'd44);
`endif
    chk("n1_ovf_carry", 64'(carry1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
